// File: rtl/sobel_sched_pkg.sv
// Shared types and constants for the Sobel window scheduler.
// Defines the pixel/window widths, plot colours and the scheduler state encoding.
package sobel_sched_pkg;

    localparam int PIX_W   = 6;
    localparam int WIN_W   = 54;
    localparam int COORD_W = 7;

    localparam logic [PIX_W-1:0] EDGE_COLOUR = 6'h3F;
    localparam logic [PIX_W-1:0] BG_COLOUR   = 6'h00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLOT_IN  = 2'd1,
        PLOT_OUT = 2'd2
    } sched_state_e;

    // A window centre is interior once two full rows and two columns precede it.
    function automatic logic is_interior(input logic [COORD_W-1:0] col,
                                         input logic [COORD_W-1:0] row);
        return (col >= 7'd2) && (row >= 7'd2);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two row memories holding the previous two image rows, sharing one address.
// Contents are intentionally unreset; downstream valid gating hides stale data.
module sobel_line_buffer
    import sobel_sched_pkg::*;
#(
    parameter int IMG_W = 100
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [COORD_W-1:0] i_addr,
    input  logic [PIX_W-1:0]   i_din,
    output logic [PIX_W-1:0]   o_r1,
    output logic [PIX_W-1:0]   o_r2
);

    logic [PIX_W-1:0] r_mem1 [IMG_W];
    logic [PIX_W-1:0] r_mem2 [IMG_W];

    assign o_r1 = r_mem1[i_addr];
    assign o_r2 = r_mem2[i_addr];

    // Row r-1 ages into row r-2 as the new pixel lands in row r-1.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem2[i_addr] <= r_mem1[i_addr];
            r_mem1[i_addr] <= i_din;
        end
    end

endmodule

// File: rtl/sobel_window_scheduler.sv
// Raster pixel intake, 3x3 window build and VGA write scheduling for a Sobel kernel.
// Define SOBEL_SCHED_PASSTHRU_EN to also plot every input pixel at the input origin.
module sobel_window_scheduler
    import sobel_sched_pkg::*;
#(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int IN_X0  = 5,
    parameter int IN_Y0  = 10,
    parameter int OUT_X0 = 85,
    parameter int OUT_Y0 = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    input  logic             edge_in,
    output logic             plot,
    output logic [8:0]       plot_x,
    output logic [7:0]       plot_y,
    output logic [PIX_W-1:0] plot_colour,
    output logic             frame_done
);

    sched_state_e       r_state;
    sched_state_e       w_next;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col_acc;
    logic [COORD_W-1:0] r_row_acc;
    logic [PIX_W-1:0]   r_pix_acc;
    logic [WIN_W-1:0]   r_win;
    logic               r_win_valid;
    logic [PIX_W-1:0]   w_lb_r1;
    logic [PIX_W-1:0]   w_lb_r2;
    logic               w_accept;
    logic               w_interior;
    logic               w_last_pix;
    logic               w_last_acc;

    assign pix_ready  = reset && (r_state == IDLE);
    assign w_accept   = pix_valid && pix_ready;
    assign w_interior = is_interior(r_col, r_row);
    assign w_last_pix = (r_col == 7'(IMG_W - 1)) && (r_row == 7'(IMG_H - 1));
    assign w_last_acc = (r_col_acc == 7'(IMG_W - 1)) && (r_row_acc == 7'(IMG_H - 1));
    assign win        = r_win;
    assign win_valid  = r_win_valid;

    sobel_line_buffer #(
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk    (clk),
        .i_we   (w_accept),
        .i_addr (r_col),
        .i_din  (pix_data),
        .o_r1   (w_lb_r1),
        .o_r2   (w_lb_r2)
    );

    // Scheduler state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Raster counters, accepted-pixel capture and window shift on each accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col       <= 7'd0;
            r_row       <= 7'd0;
            r_col_acc   <= 7'd0;
            r_row_acc   <= 7'd0;
            r_pix_acc   <= 6'd0;
            r_win       <= 54'd0;
            r_win_valid <= 1'b0;
        end else if (w_accept) begin
            if (r_col == 7'(IMG_W - 1)) begin
                r_col <= 7'd0;
                r_row <= (r_row == 7'(IMG_H - 1)) ? 7'd0 : r_row + 7'd1;
            end else begin
                r_col <= r_col + 7'd1;
            end
            r_col_acc   <= r_col;
            r_row_acc   <= r_row;
            r_pix_acc   <= pix_data;
            r_win_valid <= w_interior;
            // Fields MSB-first are w9..w1; each row slides left and takes a new right pixel.
            r_win <= {pix_data, r_win[53:48], r_win[47:42],
                      w_lb_r1,  r_win[35:30], r_win[29:24],
                      w_lb_r2,  r_win[17:12], r_win[11:6]};
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
`ifdef SOBEL_SCHED_PASSTHRU_EN
                if (w_accept) begin
                    w_next = PLOT_IN;
                end else begin
                    w_next = IDLE;
                end
`else
                if (w_accept && w_interior) begin
                    w_next = PLOT_OUT;
                end else begin
                    w_next = IDLE;
                end
`endif
            end
`ifdef SOBEL_SCHED_PASSTHRU_EN
            PLOT_IN: begin
                if (r_win_valid) begin
                    w_next = PLOT_OUT;
                end else begin
                    w_next = IDLE;
                end
            end
`endif
            PLOT_OUT: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // VGA write port decode; the edge colour follows the kernel result live.
    always_comb begin
        plot        = 1'b0;
        plot_x      = 9'd0;
        plot_y      = 8'd0;
        plot_colour = BG_COLOUR;
        frame_done  = 1'b0;
        case (r_state)
`ifdef SOBEL_SCHED_PASSTHRU_EN
            PLOT_IN: begin
                plot        = 1'b1;
                plot_x      = 9'(IN_X0) + {2'b00, r_col_acc};
                plot_y      = 8'(IN_Y0) + {1'b0, r_row_acc};
                plot_colour = r_pix_acc;
            end
`endif
            PLOT_OUT: begin
                plot        = 1'b1;
                plot_x      = 9'(OUT_X0) + {2'b00, r_col_acc} - 9'd1;
                plot_y      = 8'(OUT_Y0) + {1'b0, r_row_acc} - 8'd1;
                plot_colour = edge_in ? EDGE_COLOUR : BG_COLOUR;
                frame_done  = w_last_acc;
            end
            default: begin
`ifdef SOBEL_SCHED_PASSTHRU_EN
                frame_done = 1'b0;
`else
                // Only reachable if the last pixel never yields an edge write.
                frame_done = w_accept && w_last_pix && !w_interior;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Directed bench for sobel_window_scheduler on a 4x4 image with pixel value = raster index.
// Expectations adapt to SOBEL_SCHED_PASSTHRU_EN when it is defined for the build.
module tb_sobel_window_scheduler;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pix_valid = 1'b0;
    logic [5:0] pix_data = 6'd0;
    logic       edge_in = 1'b0;
    logic       pix_ready;
    logic [53:0] win;
    logic       win_valid;
    logic       plot;
    logic [8:0] plot_x;
    logic [7:0] plot_y;
    logic [5:0] plot_colour;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    sobel_window_scheduler #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .win         (win),
        .win_valid   (win_valid),
        .edge_in     (edge_in),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feeds npix pixels (values 0..npix-1) with pix_valid held, checking every cycle.
    task automatic run_frame(input int npix, input logic first_wv);
        logic prev_wv;
        logic had_write;
        prev_wv = first_wv;
        had_write = 1'b0;
        for (int i = 0; i < npix; i++) begin
            int  c;
            int  r;
            logic interior;
            c = i % W;
            r = i / W;
            interior = (c >= 2) && (r >= 2);
            @(negedge clk);
            chk("idle_ready", 64'(pix_ready), 64'(1'b1));
            chk("idle_plot", 64'(plot), 64'(1'b0));
            chk("idle_frame_done", 64'(frame_done), 64'(1'b0));
            chk("held_win_valid", 64'(win_valid), 64'(prev_wv));
            pix_valid = 1'b1;
            pix_data  = 6'(i);
            edge_in   = 1'b0;
            had_write = 1'b0;
`ifdef SOBEL_SCHED_PASSTHRU_EN
            @(negedge clk);
            chk("in_ready", 64'(pix_ready), 64'(1'b0));
            chk("in_plot", 64'(plot), 64'(1'b1));
            chk("in_x", 64'(plot_x), 64'(5 + c));
            chk("in_y", 64'(plot_y), 64'(10 + r));
            chk("in_colour", 64'(plot_colour), 64'(6'(i)));
            chk("in_frame_done", 64'(frame_done), 64'(1'b0));
            had_write = 1'b1;
`endif
            if (interior) begin
                @(negedge clk);
                edge_in = (i % 2) == 1;
                #1;
                chk("out_ready", 64'(pix_ready), 64'(1'b0));
                chk("out_plot", 64'(plot), 64'(1'b1));
                chk("out_x", 64'(plot_x), 64'(85 + c - 1));
                chk("out_y", 64'(plot_y), 64'(10 + r - 1));
                chk("out_colour", 64'(plot_colour), ((i % 2) == 1) ? 64'h3F : 64'h00);
                chk("out_frame_done", 64'(frame_done), 64'(i == W * H - 1));
                chk("out_win_valid", 64'(win_valid), 64'(1'b1));
                if (i == 10) begin
                    chk("win_w1", 64'(win[5:0]),   64'd0);
                    chk("win_w2", 64'(win[11:6]),  64'd1);
                    chk("win_w3", 64'(win[17:12]), 64'd2);
                    chk("win_w4", 64'(win[23:18]), 64'd4);
                    chk("win_w5", 64'(win[29:24]), 64'd5);
                    chk("win_w6", 64'(win[35:30]), 64'd6);
                    chk("win_w7", 64'(win[41:36]), 64'd8);
                    chk("win_w8", 64'(win[47:42]), 64'd9);
                    chk("win_w9", 64'(win[53:48]), 64'd10);
                end
                had_write = 1'b1;
            end
            prev_wv = interior;
        end
        if (!had_write) begin
            @(negedge clk);
        end
        pix_valid = 1'b0;
        edge_in   = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", 64'(pix_ready), 64'(1'b0));
        chk("rst_plot", 64'(plot), 64'(1'b0));
        chk("rst_x", 64'(plot_x), 64'd0);
        chk("rst_y", 64'(plot_y), 64'd0);
        chk("rst_colour", 64'(plot_colour), 64'd0);
        chk("rst_win", 64'(win), 64'd0);
        chk("rst_win_valid", 64'(win_valid), 64'(1'b0));
        chk("rst_frame_done", 64'(frame_done), 64'(1'b0));
        @(negedge clk);
        reset = 1'b1;

        run_frame(W * H, 1'b0);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gap_ready", 64'(pix_ready), 64'(1'b1));
            chk("gap_plot", 64'(plot), 64'(1'b0));
            chk("gap_win_valid", 64'(win_valid), 64'(1'b1));
        end

        run_frame(11, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_plot", 64'(plot), 64'(1'b0));
        chk("abort_ready", 64'(pix_ready), 64'(1'b0));
        chk("abort_win", 64'(win), 64'd0);
        chk("abort_win_valid", 64'(win_valid), 64'(1'b0));
        chk("abort_frame_done", 64'(frame_done), 64'(1'b0));
        @(negedge clk);
        reset = 1'b1;

        run_frame(W * H, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
